priority_encoder_scan_display: RTL and testbench



---
 rtl/priority_encoder_scan_display.sv | 174 +++++++++++++++++
 tb/tb_priority_encoder_scan_display.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_scan_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : priority_encoder_scan_display                                   |
// | Brief  : Registered MSB priority encoder with peak-hold, shown in        |
// |          decimal on a time-multiplexed common-bus 7-segment display.     |
// | Rev    : 1.0 - parametrised successor of the 8-bit encoder/display block |
// +--------------------------------------------------------------------------+
module priority_encoder_scan_display #(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         data,
  input  logic                     hold_mode,
  input  logic                     clear,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     valid,
  output logic [6:0]               segments,
  output logic [DIGITS-1:0]        digit_en,
  output logic                     none
);

  localparam int c_IW = $clog2(WIDTH);
  localparam int c_CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(SCAN_DIV - 1);

  logic [WIDTH-1:0] r_data;
  logic [c_IW-1:0]  r_live_idx;
  logic             r_live_valid;
  logic [c_IW-1:0]  r_peak_idx;
  logic             r_peak_valid;
  logic [c_CW-1:0]  r_scan_cnt;

  logic [c_IW-1:0]   w_enc_idx;
  logic              w_enc_valid;
  logic              w_scan_tc;
  logic [DIGITS-1:0] w_digit_rot;
  logic [3:0]        w_bcd [DIGITS];
  logic [DIGITS-1:0] w_blank;
  logic              w_nz_seen;
  logic [3:0]        w_sel_bcd;
  logic              w_sel_blank;

  // Priority encode of the registered request: higher set bits overwrite lower ones.
  always_comb begin
    w_enc_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_data[i]) w_enc_idx = c_IW'(i);
    end
  end
  assign w_enc_valid = |r_data;

  // Input register and live result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_live_idx   <= '0;
      r_live_valid <= 1'b0;
    end else begin
      r_data       <= data;
      r_live_idx   <= w_enc_idx;
      r_live_valid <= w_enc_valid;
    end
  end

  // Peak-hold of the registered live result; clear beats a simultaneous update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak_idx   <= '0;
      r_peak_valid <= 1'b0;
    end else if (clear) begin
      r_peak_idx   <= '0;
      r_peak_valid <= 1'b0;
    end else if (r_live_valid && (!r_peak_valid || r_live_idx > r_peak_idx)) begin
      r_peak_idx   <= r_live_idx;
      r_peak_valid <= 1'b1;
    end
  end

  // Output select. The live branch captures the encoder result on the same edge
  // that loads the live register, keeping data-to-index latency at two cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index <= '0;
      valid <= 1'b0;
      none  <= 1'b1;
    end else if (hold_mode) begin
      index <= r_peak_idx;
      valid <= r_peak_valid;
      none  <= !r_peak_valid;
    end else begin
      index <= w_enc_idx;
      valid <= w_enc_valid;
      none  <= !w_enc_valid;
    end
  end

  generate
    if (DIGITS == 1) begin : g_rot_single
      assign w_digit_rot = digit_en;
    end else begin : g_rot_multi
      assign w_digit_rot = {digit_en[DIGITS-2:0], digit_en[DIGITS-1]};
    end
  endgenerate

  assign w_scan_tc = (r_scan_cnt == c_LAST);

  // Scan timer: dwell SCAN_DIV cycles per digit, then rotate the one-hot select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      digit_en   <= DIGITS'(1);
    end else if (w_scan_tc) begin
      r_scan_cnt <= '0;
      digit_en   <= w_digit_rot;
    end else begin
      r_scan_cnt <= r_scan_cnt + c_CW'(1);
    end
  end

  // Decimal digits of the displayed index (constant divisors only).
  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_bcd
      localparam int unsigned c_POW = 10 ** k;
      assign w_bcd[k] = 4'((32'(index) / c_POW) % 32'd10);
    end
  endgenerate

  // Leading-zero blanking from the top digit down; the units digit is never blanked.
  always_comb begin
    w_nz_seen = 1'b0;
    w_blank   = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_nz_seen  = w_nz_seen | (w_bcd[k] != 4'd0);
      w_blank[k] = !w_nz_seen;
    end
  end

  // Pick the digit addressed by the one-hot select.
  always_comb begin
    w_sel_bcd   = 4'd0;
    w_sel_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_en[k]) begin
        w_sel_bcd   = w_bcd[k];
        w_sel_blank = w_blank[k];
      end
    end
  end

  // Seven-segment decode (gfedcba), dark when nothing to show or digit blanked.
  always_comb begin
    segments = 7'b0000000;
    if (!none && !w_sel_blank) begin
      case (w_sel_bcd)
        4'd0:    segments = 7'b0111111;
        4'd1:    segments = 7'b0000110;
        4'd2:    segments = 7'b1011011;
        4'd3:    segments = 7'b1001111;
        4'd4:    segments = 7'b1100110;
        4'd5:    segments = 7'b1101101;
        4'd6:    segments = 7'b1111101;
        4'd7:    segments = 7'b0000111;
        4'd8:    segments = 7'b1111111;
        4'd9:    segments = 7'b1101111;
        default: segments = 7'b0000000;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_scan_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_priority_encoder_scan_display                                |
// | Brief  : Directed + randomized bench with a behavioural reference model. |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_priority_encoder_scan_display;

  localparam int WIDTH    = 16;
  localparam int DIGITS   = 2;
  localparam int SCAN_DIV = 4;
  localparam int IW       = $clog2(WIDTH);

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b1;
  logic [WIDTH-1:0]  data      = '0;
  logic              hold_mode = 1'b0;
  logic              clear     = 1'b0;
  logic [IW-1:0]     index;
  logic              valid;
  logic [6:0]        segments;
  logic [DIGITS-1:0] digit_en;
  logic              none;

  priority_encoder_scan_display #(
    .WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .hold_mode(hold_mode), .clear(clear),
    .index(index), .valid(valid), .segments(segments), .digit_en(digit_en), .none(none)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Reference model: indices as ints, -1 meaning "nothing".
  logic [WIDTH-1:0] m_dq   = '0;
  int               m_live = -1;
  int               m_peak = -1;
  int               m_idx  = -1;
  int               m_cyc  = 0;

  function automatic int msb(input logic [WIDTH-1:0] v);
    longint x;
    int     n;
    x = longint'(v);
    n = -1;
    while (x > 0) begin
      x = x >> 1;
      n++;
    end
    return n;
  endfunction

  function automatic logic [6:0] seg_of(input int idx, input int pos);
    logic [6:0] codes [10];
    int p;
    codes = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    if (idx < 0) return 7'b0;
    p = 1;
    for (int i = 0; i < pos; i++) p = p * 10;
    if (pos > 0 && idx < p) return 7'b0;
    return codes[(idx / p) % 10];
  endfunction

  // Model: index is the live encode (or the peak, one cycle stale) and the peak
  // is the running maximum since the last clear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dq = '0; m_live = -1; m_peak = -1; m_idx = -1; m_cyc = 0;
    end else begin
      int enc;
      enc    = msb(m_dq);
      m_idx  = hold_mode ? m_peak : enc;
      m_peak = clear ? -1 : ((m_live > m_peak) ? m_live : m_peak);
      m_live = enc;
      m_dq   = data;
      m_cyc++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      int pos;
      pos = (m_cyc / SCAN_DIV) % DIGITS;
      check("index",    32'(index),    (m_idx < 0) ? 0 : m_idx);
      check("valid",    32'(valid),    32'(m_idx >= 0));
      check("none",     32'(none),     32'(m_idx < 0));
      check("digit_en", 32'(digit_en), 32'(1) << pos);
      check("segments", 32'(segments), 32'(seg_of(m_idx, pos)));
    end
  end

  task automatic wait_digit(input int k);
    for (int i = 0; i < 4 * SCAN_DIV * DIGITS; i++) begin
      if (digit_en == DIGITS'(1 << k)) return;
      @(negedge clk);
    end
    check("wait_digit_timeout", 32'(digit_en), 32'(1) << k);
  endtask

  task automatic reset_values(input string nm);
    check({nm, "_index"},    32'(index),    0);
    check({nm, "_valid"},    32'(valid),    0);
    check({nm, "_none"},     32'(none),     1);
    check({nm, "_segments"}, 32'(segments), 0);
    check({nm, "_digit_en"}, 32'(digit_en), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] bd_data [3];
    int               bd_idx  [3];
    bit               found;
    bd_data = '{16'h8000, 16'h0001, 16'hFFFF};
    bd_idx  = '{15, 0, 15};

    // Reset and idle
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_values("reset");
    cmp_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_digit_units", 32'(digit_en), 32'b01);
    @(negedge clk);
    check("idle_digit_tens", 32'(digit_en), 32'b10);
    check("idle_none", 32'(none), 1);

    // Live encode
    data = 16'h2005;
    repeat (2) @(negedge clk);
    check("live13_index", 32'(index), 13);
    check("live13_valid", 32'(valid), 1);
    check("live13_none",  32'(none),  0);
    wait_digit(0);
    check("live13_units", 32'(segments), 32'b1001111);
    wait_digit(1);
    check("live13_tens",  32'(segments), 32'b0000110);
    data = 16'h0004;
    repeat (2) @(negedge clk);
    check("live2_index", 32'(index), 2);
    wait_digit(1);
    check("live2_tens_blank", 32'(segments), 32'b0000000);
    wait_digit(0);
    check("live2_units", 32'(segments), 32'b1011011);

    // Priority boundaries
    for (int i = 0; i < 3; i++) begin
      data = bd_data[i];
      repeat (2) @(negedge clk);
      check("boundary_index", 32'(index), bd_idx[i]);
      if (i == 1) begin
        wait_digit(0);
        check("boundary0_units", 32'(segments), 32'b0111111);
        check("boundary0_none",  32'(none), 0);
      end
    end

    // Peak hold
    data = '0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; hold_mode = 1'b1; data = 16'h0010;
    repeat (4) @(negedge clk);
    check("peak_4", 32'(index), 4);
    data = 16'h0400;
    repeat (4) @(negedge clk);
    check("peak_10", 32'(index), 10);
    data = 16'h0002;
    repeat (4) @(negedge clk);
    check("peak_hold_10", 32'(index), 10);
    hold_mode = 1'b0;
    @(negedge clk);
    check("live_after_hold", 32'(index), 1);

    // Clear colliding with a higher live value
    hold_mode = 1'b1; data = 16'h1000;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    check("collide_none",  32'(none),  1);
    check("collide_valid", 32'(valid), 0);
    @(negedge clk);
    check("collide_index12", 32'(index), 12);
    check("collide_valid12", 32'(valid), 1);

    // Asynchronous reset mid-scan (tens digit, counter 2)
    hold_mode = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (digit_en == 2'b10 && (m_cyc % SCAN_DIV) == 2) found = 1'b1;
      else @(negedge clk);
    end
    check("async_setup_found", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1 reset_values("async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("post_reset_units", 32'(digit_en), 32'b01);
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);
    check("post_reset_tens", 32'(digit_en), 32'b10);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       data = '0;
        1:       data = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        2:       data = WIDTH'($urandom_range(0, 255));
        default: data = WIDTH'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) hold_mode = ~hold_mode;
      clear = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    clear = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
